// File: rtl/flux_tag_arbiter.sv
// flux_tag_arbiter: write-side front end for the shared multi-flux tagged FIFO.
// Each producer channel has a one-word holding register. A round-robin grant
// picks one held word per cycle, tags it with the channel index in the MSBs
// and writes it to the FIFO. No write is issued while the FIFO reports full.
// Optional macro FLUX_TAG_STATS_EN adds per-channel 16-bit write counters
// readable through stat_sel/stat_cnt.
module flux_tag_arbiter #(
    parameter int WIDTH     = 8,
    parameter int FLUX      = 2,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int PAY_WIDTH = WIDTH - TAG_WIDTH
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic [FLUX-1:0]           in_valid,
    input  logic [FLUX*PAY_WIDTH-1:0] in_data,
    output logic [FLUX-1:0]           in_ready,
    input  logic                      full,
    output logic                      wr,
`ifdef FLUX_TAG_STATS_EN
    input  logic [TAG_WIDTH-1:0]      stat_sel,
    output logic [15:0]               stat_cnt,
`endif
    output logic [WIDTH-1:0]          datain
);

    logic [FLUX-1:0]                hold_vld_q, hold_vld_d;
    logic [FLUX-1:0][PAY_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [TAG_WIDTH-1:0]           rr_ptr_q, rr_ptr_d;
    logic [TAG_WIDTH-1:0]           gnt;
    logic                           gnt_vld;
    logic [TAG_WIDTH:0]             idx;

    // Round-robin grant: scan from rr_ptr downward in priority so the closest
    // held channel at or after the pointer (modulo FLUX) wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (TAG_WIDTH + 1)'(k);
            if (idx >= (TAG_WIDTH + 1)'(FLUX))
                idx = idx - (TAG_WIDTH + 1)'(FLUX);
            if (hold_vld_q[idx[TAG_WIDTH-1:0]])
                gnt = idx[TAG_WIDTH-1:0];
        end
        gnt_vld = |hold_vld_q;
    end

    // FIFO write strobe and tagged data; data is forced to zero when idle.
    always_comb begin
        wr     = gnt_vld & ~full;
        datain = wr ? {gnt, hold_data_q[gnt]} : '0;
    end

    // A channel is ready when empty or when its held word leaves this cycle.
    always_comb begin
        for (int i = 0; i < FLUX; i++)
            in_ready[i] = ~hold_vld_q[i] | (wr & (gnt == TAG_WIDTH'(i)));
    end

    // Next state: capture wins over release so a word can be replaced in the
    // cycle it is written; pointer advances past the granted channel.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        for (int i = 0; i < FLUX; i++) begin
            if (in_valid[i] & in_ready[i]) begin
                hold_vld_d[i]  = 1'b1;
                hold_data_d[i] = in_data[i*PAY_WIDTH +: PAY_WIDTH];
            end else if (wr && gnt == TAG_WIDTH'(i)) begin
                hold_vld_d[i]  = 1'b0;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (wr)
            rr_ptr_d = (gnt == TAG_WIDTH'(FLUX - 1)) ? '0 : gnt + 1'b1;
    end

    // State registers; reset drops every held word at once.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold_vld_q  <= '0;
            hold_data_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef FLUX_TAG_STATS_EN
    logic [FLUX-1:0][15:0] cnt_q;

    // Per-channel write counters, wrapping at 16 bits.
    always_ff @(posedge ck or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (wr)
            cnt_q[gnt] <= cnt_q[gnt] + 16'd1;
    end

    // Counter readout; selects beyond the channel count read as zero.
    always_comb begin
        stat_cnt = 16'd0;
        if ({1'b0, stat_sel} < (TAG_WIDTH + 1)'(FLUX))
            stat_cnt = cnt_q[stat_sel];
    end
`else
    // Statistics disabled: no counters or readout ports.
`endif

endmodule

// File: tb/tb_flux_tag_arbiter.sv
// Directed bench for flux_tag_arbiter (WIDTH=8, FLUX=2, 7-bit payloads).
module tb_flux_tag_arbiter;

    logic        ck = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [13:0] in_data;
    logic [1:0]  in_ready;
    logic        full;
    logic        wr;
    logic [7:0]  datain;
`ifdef FLUX_TAG_STATS_EN
    logic        stat_sel;
    logic [15:0] stat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    flux_tag_arbiter #(.WIDTH(8), .FLUX(2)) dut (
        .ck       (ck),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .full     (full),
        .wr       (wr),
`ifdef FLUX_TAG_STATS_EN
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt),
`endif
        .datain   (datain)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; full = 1'b0; in_valid = 2'b11; in_data = {7'h55, 7'h2A};
        step(); step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", wr); end
        checks++; if (datain !== 8'h00) begin failures++; $display("FAIL reset_datain got=%h exp=00", datain); end
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL reset_in_ready got=%b exp=11", in_ready); end
        in_valid = 2'b00;
        rst = 1'b0;
        #1;
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL post_reset_wr0 got=%b exp=0", wr); end
        step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL post_reset_wr1 got=%b exp=0", wr); end
    endtask

    task automatic test_single();
        in_valid = 2'b01; in_data = {7'h00, 7'h15};
        step();
        in_valid = 2'b00;
        checks++; if (wr !== 1'b1) begin failures++; $display("FAIL single0_wr got=%b exp=1", wr); end
        checks++; if (datain !== 8'h15) begin failures++; $display("FAIL single0_datain got=%h exp=15", datain); end
        step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL single0_idle got=%b exp=0", wr); end
        in_valid = 2'b10; in_data = {7'h15, 7'h00};
        step();
        in_valid = 2'b00;
        checks++; if (wr !== 1'b1) begin failures++; $display("FAIL single1_wr got=%b exp=1", wr); end
        checks++; if (datain !== 8'h95) begin failures++; $display("FAIL single1_datain got=%h exp=95", datain); end
        step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL single1_idle got=%b exp=0", wr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        logic [1:0] exp_r;
        in_valid = 2'b11; in_data = {7'h02, 7'h01};
        for (int i = 0; i < 6; i++) begin
            step();
            exp_d = (i % 2 == 0) ? 8'h01 : 8'h82;
            exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (wr !== 1'b1) begin failures++; $display("FAIL b2b_wr[%0d] got=%b exp=1", i, wr); end
            checks++; if (datain !== exp_d) begin failures++; $display("FAIL b2b_datain[%0d] got=%h exp=%h", i, datain, exp_d); end
            checks++; if (in_ready !== exp_r) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_r); end
        end
        in_valid = 2'b00;
        step();
        checks++; if (datain !== 8'h01 || wr !== 1'b1) begin failures++; $display("FAIL b2b_drain wr=%b datain=%h exp wr=1 datain=01", wr, datain); end
        step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", wr); end
    endtask

    task automatic test_full_stall();
        // A lone channel-0 write leaves rr_ptr at 1.
        in_valid = 2'b01; in_data = {7'h00, 7'h01};
        step();
        in_valid = 2'b00;
        step();
        in_valid = 2'b11; in_data = {7'h02, 7'h01};
        step();
        in_valid = 2'b00; full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (wr !== 1'b0) begin failures++; $display("FAIL full_wr[%0d] got=%b exp=0", i, wr); end
            checks++; if (in_ready !== 2'b00) begin failures++; $display("FAIL full_in_ready[%0d] got=%b exp=00", i, in_ready); end
            checks++; if (datain !== 8'h00) begin failures++; $display("FAIL full_datain[%0d] got=%h exp=00", i, datain); end
            step();
        end
        full = 1'b0;
        #1;
        checks++; if (wr !== 1'b1 || datain !== 8'h82) begin failures++; $display("FAIL resume_first wr=%b datain=%h exp wr=1 datain=82", wr, datain); end
        checks++; if (in_ready !== 2'b10) begin failures++; $display("FAIL resume_in_ready got=%b exp=10", in_ready); end
        step();
        checks++; if (wr !== 1'b1 || datain !== 8'h01) begin failures++; $display("FAIL resume_second wr=%b datain=%h exp wr=1 datain=01", wr, datain); end
        step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL resume_empty got=%b exp=0", wr); end
    endtask

    task automatic test_reset_mid();
        full = 1'b1; in_valid = 2'b01; in_data = {7'h00, 7'h33};
        step();
        in_valid = 2'b00;
        checks++; if (in_ready !== 2'b10 || wr !== 1'b0) begin failures++; $display("FAIL midrst_held in_ready=%b wr=%b exp in_ready=10 wr=0", in_ready, wr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL midrst_cleared got=%b exp=11", in_ready); end
        #2 rst = 1'b0; full = 1'b0;
        #1;
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL midrst_wr0 got=%b exp=0", wr); end
        step();
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL midrst_wr1 got=%b exp=0", wr); end
    endtask

`ifdef FLUX_TAG_STATS_EN
    task automatic test_stats();
        rst = 1'b1; full = 1'b0; in_valid = 2'b00; stat_sel = 1'b0;
        step();
        rst = 1'b0;
        in_valid = 2'b01; in_data = {7'h00, 7'h11};
        repeat (3) step();
        in_valid = 2'b00;
        step();
        in_valid = 2'b10; in_data = {7'h22, 7'h00};
        repeat (2) step();
        in_valid = 2'b00;
        repeat (2) step();
        stat_sel = 1'b0; #1;
        checks++; if (stat_cnt !== 16'd3) begin failures++; $display("FAIL stats_ch0 got=%0d exp=3", stat_cnt); end
        stat_sel = 1'b1; #1;
        checks++; if (stat_cnt !== 16'd2) begin failures++; $display("FAIL stats_ch1 got=%0d exp=2", stat_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0; stat_sel = 1'b0;
        in_valid = 2'b01; in_data = {7'h00, 7'h7F};
        repeat (65537) step();
        in_valid = 2'b00;
        repeat (2) step();
        checks++; if (stat_cnt !== 16'd1) begin failures++; $display("FAIL stats_wrap got=%0d exp=1", stat_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_reset_mid();
`ifdef FLUX_TAG_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
